// File: rtl/fft_cmult_seq_pkg.sv
// Shared types and constants for the sequential FFT twiddle multiplier.
package fft_cmult_seq_pkg;

  localparam int DATA_W = 12;
  localparam int PROD_W = 24;
  localparam int ACC_W  = 25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_e;

  // Order in which the four partial products are issued.
  localparam logic [1:0] P_RR = 2'd0;
  localparam logic [1:0] P_II = 2'd1;
  localparam logic [1:0] P_RI = 2'd2;
  localparam logic [1:0] P_IR = 2'd3;

  typedef struct packed {
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;
  } operands_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } mul_ops_t;

  function automatic mul_ops_t sel_operands(input operands_t ops, input logic [1:0] idx);
    mul_ops_t m;
    case (idx)
      P_RR:    begin m.a = ops.a_re; m.b = ops.w_re; end
      P_II:    begin m.a = ops.a_im; m.b = ops.w_im; end
      P_RI:    begin m.a = ops.a_re; m.b = ops.w_im; end
      default: begin m.a = ops.a_im; m.b = ops.w_re; end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Combinational round-half-up arithmetic right shift followed by saturation
// to a signed OUT_W result.
module fft_round_sat #(
  parameter int IN_W      = 25,
  parameter int FRAC_BITS = 11,
  parameter int OUT_W     = 12
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] y
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum     = SUM_W'(acc) + ROUND_C;
    shifted = sum >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      y = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      y = SAT_MIN[OUT_W-1:0];
    end else begin
      y = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fft_cmult_seq.sv
// Sequential complex multiplier: four real products through one shared
// external multiplier, accumulated, rounded, saturated, handed off valid/ready.
module fft_cmult_seq
  import fft_cmult_seq_pkg::*;
#(
  parameter int FRAC_BITS   = 11,
  parameter int OUT_W       = 12,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] w_re,
  input  logic signed [DATA_W-1:0] w_im,
  output logic                     mul_en,
  output logic signed [DATA_W-1:0] mul_a,
  output logic signed [DATA_W-1:0] mul_b,
  input  logic signed [PROD_W-1:0] mul_p,
  input  logic                     mul_rdy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y_re,
  output logic signed [OUT_W-1:0]  y_im,
  output logic                     err
);

  localparam int TMO_W = $clog2(MUL_TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  operands_t                ops_q, ops_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic                     in_ready_q, in_ready_d;
  logic                     mul_en_q, mul_en_d;
  logic signed [DATA_W-1:0] mul_a_q, mul_a_d;
  logic signed [DATA_W-1:0] mul_b_q, mul_b_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  y_re_q, y_re_d;
  logic signed [OUT_W-1:0]  y_im_q, y_im_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  p_ext;
  logic signed [OUT_W-1:0]  rnd_re, rnd_im;
  mul_ops_t                 nxt_ops;

  fft_round_sat #(.IN_W(ACC_W), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_rs_re (
    .acc (acc_re_q),
    .y   (rnd_re)
  );

  fft_round_sat #(.IN_W(ACC_W), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_rs_im (
    .acc (acc_im_q),
    .y   (rnd_im)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    ops_d       = ops_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    mul_en_d    = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    y_re_d      = y_re_q;
    y_im_d      = y_im_q;
    err_d       = 1'b0;
    p_ext       = ACC_W'(mul_p);
    nxt_ops     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          ops_d.a_re = a_re;
          ops_d.a_im = a_im;
          ops_d.w_re = w_re;
          ops_d.w_im = w_im;
          acc_re_d   = '0;
          acc_im_d   = '0;
          idx_d      = P_RR;
          nxt_ops    = sel_operands(ops_d, P_RR);
          mul_a_d    = nxt_ops.a;
          mul_b_d    = nxt_ops.b;
          mul_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_rdy) begin
          case (idx_q)
            P_RR:    acc_re_d = acc_re_q + p_ext;
            P_II:    acc_re_d = acc_re_q - p_ext;
            default: acc_im_d = acc_im_q + p_ext;
          endcase
          if (idx_q == P_IR) begin
            state_d = ROUND;
          end else begin
            idx_d    = idx_q + 2'd1;
            nxt_ops  = sel_operands(ops_q, idx_d);
            mul_a_d  = nxt_ops.a;
            mul_b_d  = nxt_ops.b;
            mul_en_d = 1'b1;
            state_d  = ISSUE;
          end
        end else if (tmo_q == TMO_W'(MUL_TIMEOUT - 1)) begin
          // MUL_TIMEOUT wait cycles have now elapsed without a product.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ROUND: begin
        y_re_d      = rnd_re;
        y_im_d      = rnd_im;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      ops_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      in_ready_q  <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      ops_q       <= ops_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      in_ready_q  <= in_ready_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      y_re_q      <= y_re_d;
      y_im_q      <= y_im_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fft_cmult_seq.sv
// Self-checking bench for fft_cmult_seq: behavioural multiplier with variable
// latency, real-arithmetic reference for the complex product, directed corners.
module tb_fft_cmult_seq;

  localparam int FRAC_BITS   = 11;
  localparam int OUT_W       = 12;
  localparam int MUL_TIMEOUT = 64;
  localparam int LOG_N       = 2048;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic signed [11:0] a_re, a_im, w_re, w_im;
  logic               mul_en;
  logic signed [11:0] mul_a, mul_b;
  logic signed [23:0] mul_p;
  logic               mul_rdy;
  logic               out_valid, out_ready;
  logic signed [11:0] y_re, y_im;
  logic               err;

  always #5 clk = ~clk;

  fft_cmult_seq #(.FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .mul_rdy   (mul_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_re      (y_re),
    .y_im      (y_im),
    .err       (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural shared multiplier: product appears mul_lat cycles after mul_en.
  int                 mul_lat   = 6;
  bit                 mul_dead  = 1'b0;
  bit                 stale_req = 1'b0;
  int                 mul_en_cnt = 0;
  int                 op_a_log [LOG_N];
  int                 op_b_log [LOG_N];
  bit                 pend = 1'b0;
  int                 pend_cnt = 0;
  logic signed [23:0] pend_p;

  always @(negedge clk) begin
    mul_rdy = stale_req;
    mul_p   = stale_req ? 24'sh3FFFFF : 24'($urandom);
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mul_rdy = 1'b1;
        mul_p   = pend_p;
        pend    = 1'b0;
      end
    end
    if (mul_en) begin
      if (mul_en_cnt < LOG_N) begin
        op_a_log[mul_en_cnt] = int'(mul_a);
        op_b_log[mul_en_cnt] = int'(mul_b);
      end
      mul_en_cnt++;
      if (!mul_dead) begin
        pend     = 1'b1;
        pend_cnt = mul_lat;
        pend_p   = mul_a * mul_b;
      end
    end
  end

  function automatic int ref_round(input longint acc);
    real v;
    int  r;
    v = $floor(real'(acc) / real'(1 << FRAC_BITS) + 0.5);
    r = int'(v);
    if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
    if (r < -(1 << (OUT_W - 1)))    r = -(1 << (OUT_W - 1));
    return r;
  endfunction

  // Presents one operand set; returns at the negedge after the accepting edge.
  task automatic send(input int ar, input int ai, input int wr, input int wi,
                      output int base);
    bit ok = 1'b0;
    @(negedge clk);
    a_re = 12'(ar); a_im = 12'(ai); w_re = 12'(wr); w_im = 12'(wi);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", ok, 1);
    @(posedge clk);
    base = mul_en_cnt;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_txn(input int ar, input int ai, input int wr, input int wi,
                        input int lat, input int hold);
    int     base, n;
    longint re, im;
    int     exp_re, exp_im;
    int     exp_a[4], exp_b[4];
    bit     bp_bad = 1'b0;
    re = longint'(ar) * wr - longint'(ai) * wi;
    im = longint'(ar) * wi + longint'(ai) * wr;
    exp_re = ref_round(re);
    exp_im = ref_round(im);
    exp_a = '{ar, ai, ar, ai};
    exp_b = '{wr, wi, wi, wr};
    mul_lat = lat;
    send(ar, ai, wr, wi, base);
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, 4 * (lat + 1) + 1);
    check("mul_en_pulses", mul_en_cnt - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < LOG_N) begin
        check($sformatf("op_a[%0d]", k), op_a_log[base + k], exp_a[k]);
        check($sformatf("op_b[%0d]", k), op_b_log[base + k], exp_b[k]);
      end
    end
    check("y_re", y_re, exp_re);
    check("y_im", y_im, exp_im);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (y_re !== 12'(exp_re) || y_im !== 12'(exp_im) || out_valid !== 1'b1 || in_ready !== 1'b0)
        bp_bad = 1'b1;
    end
    if (hold > 0) check("backpressure_hold", bp_bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_rise", in_ready, 1);
  endtask

  initial begin
    int base, n;
    bit bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_y_re", y_re, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Rounding at half, negative halves, saturation, backpressure.
    do_txn(1024, 0, 2047, 0, 6, 0);
    do_txn(-1, 0, 1024, 0, 3, 0);
    do_txn(-3, 0, 1024, 0, 2, 0);
    do_txn(-2048, -2048, -2048, 2048 - 1, 4, 0);
    do_txn(-2048, -2048, -2048, -2048, 1, 0);
    do_txn(2047, 0, -2048, 0, 5, 0);
    do_txn(700, -300, 1448, -1448, 6, 10);

    // Multiplier never answers: one err pulse, no result, then recovery.
    mul_dead = 1'b1;
    send(300, -200, 1500, -900, base);
    n = 0;
    bad = 1'b0;
    while (!err && n < 200) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("tmo_err_delay", n, MUL_TIMEOUT + 1);
    check("tmo_in_ready", in_ready, 1);
    check("tmo_issues", mul_en_cnt - base, 1);
    @(negedge clk);
    check("tmo_err_single", err, 0);
    for (int i = 0; i < 20; i++) begin
      if (out_valid || err) bad = 1'b1;
      @(negedge clk);
    end
    check("tmo_no_output", bad, 0);
    mul_dead = 1'b0;
    do_txn(300, -200, 1500, -900, 3, 0);

    // Reset during the WAIT of the third product, then a stale mul_rdy.
    mul_lat = 6;
    send(500, 300, 1000, -700, base);
    bad = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (mul_en_cnt - base == 3) begin
        bad = 1'b0;
        break;
      end
    end
    check("reach_idx2", bad, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_mul_en", mul_en, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_y_re", y_re, 0);
    check("mid_rst_y_im", y_im, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 stale_req = 1'b1;
    @(posedge clk);
    #1 stale_req = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    do_txn(100, 50, 2047, -2047, 3, 0);

    // Randomised operands, latencies and backpressure.
    for (int t = 0; t < 20; t++) begin
      do_txn(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
